stm1_framer: RTL and testbench
==============================

STM1_FRAMER -- requirements
Module: stm1_framer

Interface
REQ-001 SHALL have parameter STM1_LENGTH, default 270, meaning columns per STM-1 row.
REQ-002 SHALL have parameter STM1_WIDTH, default 9, meaning rows per STM-1 frame.
REQ-003 SHALL have parameter OH_COLS, default 9, meaning section-overhead columns per row; payload columns = STM1_LENGTH-OH_COLS (261, matching VC4 length).
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port in_data, input, 8, meaning VC4 payload byte, row-major.
REQ-007 SHALL have port in_valid, input, 1, meaning in_data valid.
REQ-008 SHALL have port in_ready, output, 1, meaning framer accepts in_data this cycle.
REQ-009 SHALL have port out_data, output, 8, meaning STM-1 byte stream.
REQ-010 SHALL have port out_valid, output, 1, meaning out_data valid.
REQ-011 SHALL have port out_ready, input, 1, meaning downstream accepts out_data.
REQ-012 SHALL have port out_sof, output, 1, meaning out_data is row 0 column 0.
REQ-013 SHALL have port out_sor, output, 1, meaning out_data is column 0 of any row.
REQ-014 SHALL have port frame_cnt, output, 16, meaning completed frames, wrapping at 0xFFFF->0.

Function
REQ-015 SHALL use states IDLE, OH, PAYLOAD, with row counter 0..STM1_WIDTH-1 and column counter 0..STM1_LENGTH-1 naming the next byte to be generated.
REQ-016 SHALL hold a single output register; it loads when !out_valid || out_ready ("load slot"); a transfer occurs when out_valid && out_ready.
REQ-017 SHALL stay in IDLE with in_ready=0 until in_valid=1, then go to OH at row 0 col 0 the next cycle without consuming input.
REQ-018 SHALL in OH, at each load slot, load the overhead byte for column c (c<OH_COLS) with no input consumption: c0 0x50 'P', c1 0x41 'A', c2 0x52 'R', c3 0x4D 'M', c4 0x41 'A', c5 0x4E 'N', c6..c8 0x20 SPACE; identical in every row.
REQ-019 SHALL in PAYLOAD drive in_ready = load slot (combinational); on in_valid && in_ready load in_data; latency one cycle from input acceptance to out_data.
REQ-020 SHALL on payload underflow (in_valid=0) deassert out_valid after any pending transfer and hold counters; no filler bytes.
REQ-021 SHALL advance the column on each load, go OH->PAYLOAD at col OH_COLS, wrap col STM1_LENGTH-1 -> 0 and increment row (PAYLOAD->OH).
REQ-022 SHALL on loading row STM1_WIDTH-1 col STM1_LENGTH-1 increment frame_cnt in the same edge and continue at row 0 col 0 in OH (never revisits IDLE).
REQ-023 SHALL register out_sof and out_sor alongside out_data; they are meaningful only while out_valid=1.
REQ-024 SHALL hold out_data, out_valid, out_sof, out_sor stable while out_valid=1 and out_ready=0.
REQ-025 SHALL never assert in_ready in IDLE or OH.

Reset
REQ-026 SHALL on rst_n=0 immediately set state IDLE, row=0, col=0, out_valid=0, out_data=0x00, out_sof=0, out_sor=0, frame_cnt=0, BIP accumulators=0.
REQ-027 SHALL on reset mid-frame discard the partial frame; the next frame restarts at row 0 col 0 after IDLE.

Configuration
REQ-028 SHALL, with STM1_BIP8_EN defined, replace the byte at row 1 col 0 with BIP-8 (bytewise XOR) of all bytes loaded in the previous complete frame; 0x00 for the first frame after reset.
REQ-029 SHALL, without STM1_BIP8_EN, emit the REQ-018 table byte (0x50) at row 1 col 0 and contain no BIP logic.

Verification
REQ-030 SHALL test: reset, in_valid=1 constant, out_ready=1 -> first out byte 0x50 with out_sof=1, bytes 2..9 = 0x41,0x52,0x4D,0x41,0x4E,0x20,0x20,0x20, then payload.
REQ-031 SHALL test: 2349 payload bytes 0x00..0xFF repeating, out_ready=1 -> exactly 2430 output bytes per frame, out_sor every 270 bytes, frame_cnt=1 after last byte.
REQ-032 SHALL test: out_ready=0 for 5 cycles mid-payload -> out_data stable, in_ready=0, no byte lost or duplicated.
REQ-033 SHALL test: in_valid=0 for 3 cycles at row 4 col 100 -> out_valid low, column continues at 100 when input resumes.
REQ-034 SHALL test: rst_n pulsed low at row 5 -> all outputs 0 immediately; next frame begins with out_sof=1 and 0x50.
REQ-035 SHALL test, with STM1_BIP8_EN: frame 1 row 1 col 0 = 0x00; frame 2 row 1 col 0 = XOR of all 2430 frame-1 bytes as computed by the reference model.

Source files
------------

// File: rtl/stm1_framer.sv
`default_nettype none
// =============================================================================
// Module      : stm1_framer
// Description : Builds an STM-1 byte stream from a row-major VC4 payload by
//               inserting section-overhead columns. Optional macro
//               STM1_BIP8_EN places a frame BIP-8 at row 1 column 0.
// Revision    : 1.0 - initial release
// =============================================================================
module stm1_framer #(
    parameter int STM1_LENGTH = 270,
    parameter int STM1_WIDTH  = 9,
    parameter int OH_COLS     = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sof,
    output logic        out_sor,
    output logic [15:0] frame_cnt
);

    localparam int COL_W = $clog2(STM1_LENGTH);
    localparam int ROW_W = $clog2(STM1_WIDTH);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(STM1_LENGTH - 1);
    localparam logic [COL_W-1:0] OH_LAST  = COL_W'(OH_COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(STM1_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OH      = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             sof_q, sof_d;
    logic             sor_q, sor_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;

    logic             load_slot;
    logic             load;
    logic [7:0]       load_byte;
    logic [7:0]       oh_byte;

`ifdef STM1_BIP8_EN
    logic [7:0]       bip_acc_q, bip_acc_d;
    logic [7:0]       bip_prev_q, bip_prev_d;
`endif

    assign load_slot = !valid_q || out_ready;

    always_comb begin
        oh_byte = 8'h20;
        case (col_q)
            COL_W'(0): oh_byte = 8'h50;
            COL_W'(1): oh_byte = 8'h41;
            COL_W'(2): oh_byte = 8'h52;
            COL_W'(3): oh_byte = 8'h4D;
            COL_W'(4): oh_byte = 8'h41;
            COL_W'(5): oh_byte = 8'h4E;
            default:   oh_byte = 8'h20;
        endcase
`ifdef STM1_BIP8_EN
        if (row_q == ROW_W'(1) && col_q == COL_W'(0)) begin
            oh_byte = bip_prev_q;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        data_d      = data_q;
        valid_d     = valid_q;
        sof_d       = sof_q;
        sor_d       = sor_q;
        frame_cnt_d = frame_cnt_q;
        in_ready    = 1'b0;
        load        = 1'b0;
        load_byte   = 8'h00;
`ifdef STM1_BIP8_EN
        bip_acc_d   = bip_acc_q;
        bip_prev_d  = bip_prev_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_OH;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            ST_OH: begin
                if (load_slot) begin
                    load      = 1'b1;
                    load_byte = oh_byte;
                end
            end
            ST_PAYLOAD: begin
                in_ready = load_slot;
                if (load_slot) begin
                    if (in_valid) begin
                        load      = 1'b1;
                        load_byte = in_data;
                    end else begin
                        // Underflow: drop valid, counters wait for input.
                        valid_d = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            data_d  = load_byte;
            valid_d = 1'b1;
            sof_d   = (row_q == '0) && (col_q == '0);
            sor_d   = (col_q == '0);
`ifdef STM1_BIP8_EN
            bip_acc_d = bip_acc_q ^ load_byte;
`endif
            if (col_q == COL_LAST) begin
                col_d   = '0;
                state_d = ST_OH;
                if (row_q == ROW_LAST) begin
                    row_d       = '0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
`ifdef STM1_BIP8_EN
                    bip_prev_d = bip_acc_q ^ load_byte;
                    bip_acc_d  = 8'h00;
`endif
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end else begin
                col_d = col_q + COL_W'(1);
                if (col_q == OH_LAST) begin
                    state_d = ST_PAYLOAD;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            sof_q       <= 1'b0;
            sor_q       <= 1'b0;
            frame_cnt_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            sof_q       <= sof_d;
            sor_q       <= sor_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

`ifdef STM1_BIP8_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bip_acc_q  <= 8'h00;
            bip_prev_q <= 8'h00;
        end else begin
            bip_acc_q  <= bip_acc_d;
            bip_prev_q <= bip_prev_d;
        end
    end
`endif

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_sof   = sof_q;
    assign out_sor   = sor_q;
    assign frame_cnt = frame_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_stm1_framer.sv
`default_nettype none
// =============================================================================
// Module      : tb_stm1_framer
// Description : Self-checking bench for stm1_framer against a frame-position
//               reference model (honours STM1_BIP8_EN).
// Revision    : 1.0 - initial release
// =============================================================================
module tb_stm1_framer;

    localparam int LEN   = 270;
    localparam int ROWS  = 9;
    localparam int OHC   = 9;
    localparam int FRAME = LEN * ROWS;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sof;
    logic        out_sor;
    logic [15:0] frame_cnt;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    stm1_framer #(.STM1_LENGTH(LEN), .STM1_WIDTH(ROWS), .OH_COLS(OHC)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sof(out_sof), .out_sor(out_sor), .frame_cnt(frame_cnt)
    );

    // Reference model: every output byte is placed by its frame position.
    logic [7:0] oh_tab [OHC] = '{8'h50, 8'h41, 8'h52, 8'h4D, 8'h41, 8'h4E, 8'h20, 8'h20, 8'h20};
    logic [7:0] pay_q [$];
    int         mdl_pos    = 0;
    int         mdl_frames = 0;
    logic [7:0] mdl_acc    = 8'h00;
    logic [7:0] mdl_bip    = 8'h00;

    logic       hold = 1'b0;
    logic [7:0] hold_data;
    logic       hold_sof, hold_sor;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            hold = 1'b0;
        end else begin
            int         r;
            int         c;
            int         nc;
            logic [7:0] exp;
            if (hold) begin
                chk("hold_valid", {15'd0, out_valid}, 16'd1);
                chk("hold_data", {8'd0, out_data}, {8'd0, hold_data});
                chk("hold_flags", {14'd0, out_sof, out_sor}, {14'd0, hold_sof, hold_sor});
            end
            if (out_valid) begin
                nc = (mdl_pos + 1) % LEN;
                chk("in_ready", {15'd0, in_ready}, (nc < OHC) ? 16'd0 : {15'd0, out_ready});
            end
            if (out_valid && out_ready) begin
                r = mdl_pos / LEN;
                c = mdl_pos % LEN;
                exp = 8'h00;
                if (c < OHC) begin
                    exp = oh_tab[c];
`ifdef STM1_BIP8_EN
                    if (r == 1 && c == 0) exp = mdl_bip;
`endif
                end else begin
                    n_chk++;
                    assert (pay_q.size() > 0) else begin
                        n_err++;
                        $error("FAIL payload_avail observed=empty expected=byte at pos %0d", mdl_pos);
                    end
                    if (pay_q.size() > 0) exp = pay_q.pop_front();
                end
                chk("out_data", {8'd0, out_data}, {8'd0, exp});
                chk("out_sof", {15'd0, out_sof}, (mdl_pos == 0) ? 16'd1 : 16'd0);
                chk("out_sor", {15'd0, out_sor}, (c == 0) ? 16'd1 : 16'd0);
                if (mdl_pos == 0) chk("frame_cnt_sof", frame_cnt, mdl_frames[15:0]);
                mdl_acc = mdl_acc ^ exp;
                mdl_pos++;
                if (mdl_pos == FRAME) begin
                    mdl_pos    = 0;
                    mdl_frames++;
                    mdl_bip    = mdl_acc;
                    mdl_acc    = 8'h00;
                end
            end
            if (in_valid && in_ready) pay_q.push_back(in_data);
            hold      = out_valid && !out_ready;
            hold_data = out_data;
            hold_sof  = out_sof;
            hold_sor  = out_sor;
        end
    end

    logic       rnd_mode = 1'b0;
    logic [7:0] inc_val  = 8'h00;

    task automatic cyc(input logic v, input logic r, output logic ov, output logic ir);
        logic acc;
        in_valid  = v;
        out_ready = r;
        @(negedge clk);
        ov  = out_valid;
        ir  = in_ready;
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
        if (acc) begin
            inc_val = inc_val + 8'd1;
            in_data = rnd_mode ? 8'($urandom) : inc_val;
        end
    endtask

    task automatic reset_model();
        pay_q.delete();
        mdl_pos    = 0;
        mdl_frames = 0;
        mdl_acc    = 8'h00;
        mdl_bip    = 8'h00;
    endtask

    initial begin
        logic ov, ir;
        int   guard;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_data   = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_out_data", {8'd0, out_data}, 16'd0);
        chk("rst_flags", {14'd0, out_sof, out_sor}, 16'd0);
        chk("rst_frame_cnt", frame_cnt, 16'd0);
        chk("rst_in_ready", {15'd0, in_ready}, 16'd0);
        rst_n = 1'b1;

        // IDLE holds until in_valid appears.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, ov, ir);
            chk("idle_valid", {15'd0, ov}, 16'd0);
            chk("idle_in_ready", {15'd0, ir}, 16'd0);
        end

        // Full first frame, incrementing payload, no backpressure.
        guard = 0;
        while (mdl_frames < 1 && guard < 3000) begin
            cyc(1'b1, 1'b1, ov, ir);
            guard++;
        end
        chk("frame1_done", mdl_frames[15:0], 16'd1);
        chk("frame_cnt_1", frame_cnt, 16'd1);

        // Backpressure mid-payload.
        guard = 0;
        while (mdl_pos != 50 && guard < 200) begin
            cyc(1'b1, 1'b1, ov, ir);
            guard++;
        end
        chk("reach_pos50", mdl_pos[15:0], 16'd50);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, ov, ir);
            chk("bp_in_ready", {15'd0, ir}, 16'd0);
            chk("bp_valid", {15'd0, ov}, 16'd1);
        end

        // Underflow with the counter at row 4 column 100.
        guard = 0;
        while (mdl_pos != 4 * LEN + 99 && guard < 2000) begin
            cyc(1'b1, 1'b1, ov, ir);
            guard++;
        end
        chk("reach_r4c99", mdl_pos[15:0], 16'(4 * LEN + 99));
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, ov, ir);
            if (i > 0) chk("uflow_valid", {15'd0, ov}, 16'd0);
        end
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, ov, ir);
        chk("resume_pos", mdl_pos[15:0], 16'(4 * LEN + 100 + 19));

        // Asynchronous reset at row 5.
        guard = 0;
        while (mdl_pos != 5 * LEN + 30 && guard < 2000) begin
            cyc(1'b1, 1'b1, ov, ir);
            guard++;
        end
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("arst_out_data", {8'd0, out_data}, 16'd0);
        chk("arst_flags", {14'd0, out_sof, out_sor}, 16'd0);
        chk("arst_frame_cnt", frame_cnt, 16'd0);
        chk("arst_in_ready", {15'd0, in_ready}, 16'd0);
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Random valid/ready and random payload over two frames.
        rnd_mode = 1'b1;
        guard = 0;
        while (mdl_frames < 2 && guard < 30000) begin
            cyc($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, ov, ir);
            guard++;
        end
        chk("rand_frames", mdl_frames[15:0], 16'd2);
        chk("frame_cnt_2", frame_cnt, 16'd2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
